// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU stage between two requesters.
// Latches the winner's op/operands at the unit input, waits LATENCY edges, returns the result with a done pulse.
module alu_share_arbiter #(
  parameter int unsigned W       = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic         p_reset,
  input  logic         m_clock,
  input  logic         req0,
  input  logic [2:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  output logic         done0,
  output logic [W-1:0] res0,
  input  logic         req1,
  input  logic [2:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         done1,
  output logic [W-1:0] res1,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_f,
  output logic         busy
);

  // Counter must reach LATENCY and tolerate the increment on the capture edge.
  localparam int unsigned CW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } alu_cmd_t;

  state_t        state_q, state_d;
  alu_cmd_t      cmd_q, cmd_d;
  alu_cmd_t      cmd0_c, cmd1_c;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          pick_c;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res0_d, res1_d;
  logic          done0_d, done1_d;
  logic          busy_d;

  assign cmd0_c = alu_cmd_t'{op: op0, a: a0, b: b0};
  assign cmd1_c = alu_cmd_t'{op: op1, a: a1, b: b1};

  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign pick_c = (req0 && req1) ? ~last_q : req1;

  assign alu_op = cmd_q.op;
  assign alu_a  = cmd_q.a;
  assign alu_b  = cmd_q.b;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    res0_d  = res0;
    res1_d  = res1;
    done0_d = 1'b0;
    done1_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pick_c;
          last_d  = pick_c;
          cmd_d   = pick_c ? cmd1_c : cmd0_c;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LATENCY)) begin
          if (gnt_q) begin
            res1_d  = alu_f;
            done1_d = 1'b1;
          end else begin
            res0_d  = alu_f;
            done0_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      res0    <= '0;
      res1    <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      res0    <= res0_d;
      res1    <= res1_d;
      done0   <= done0_d;
      done1   <= done1_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: LATENCY=1 and LATENCY=3 instances, each driving an a&b pipeline unit,
// checked every cycle against a transaction-level model, plus directed scenarios with literal expectations.
module tb_alu_share_arbiter;

  localparam int unsigned W = 8;

  logic         m_clock;
  logic         p_reset;
  logic         req0_s [2];
  logic         req1_s [2];
  logic [2:0]   op0_s  [2];
  logic [2:0]   op1_s  [2];
  logic [W-1:0] a0_s   [2];
  logic [W-1:0] b0_s   [2];
  logic [W-1:0] a1_s   [2];
  logic [W-1:0] b1_s   [2];
  logic         done0_s[2];
  logic         done1_s[2];
  logic [W-1:0] res0_s [2];
  logic [W-1:0] res1_s [2];
  logic [2:0]   alu_op_s[2];
  logic [W-1:0] alu_a_s[2];
  logic [W-1:0] alu_b_s[2];
  logic [W-1:0] alu_f_s[2];
  logic         busy_s [2];

  int checks = 0;
  int errors = 0;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int unsigned LAT = (k == 0) ? 1 : 3;
    logic [W-1:0] pipe [3];

    alu_share_arbiter #(.W(W), .LATENCY(LAT)) dut (
      .p_reset(p_reset),
      .m_clock(m_clock),
      .req0   (req0_s[k]),
      .op0    (op0_s[k]),
      .a0     (a0_s[k]),
      .b0     (b0_s[k]),
      .done0  (done0_s[k]),
      .res0   (res0_s[k]),
      .req1   (req1_s[k]),
      .op1    (op1_s[k]),
      .a1     (a1_s[k]),
      .b1     (b1_s[k]),
      .done1  (done1_s[k]),
      .res1   (res1_s[k]),
      .alu_op (alu_op_s[k]),
      .alu_a  (alu_a_s[k]),
      .alu_b  (alu_b_s[k]),
      .alu_f  (alu_f_s[k]),
      .busy   (busy_s[k])
    );

    // Shared unit: LAT-stage registered a&b.
    always @(posedge m_clock) begin
      pipe[0] <= alu_a_s[k] & alu_b_s[k];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign alu_f_s[k] = pipe[LAT-1];
  end

  initial begin
    m_clock = 1'b0;
    forever #5 m_clock = ~m_clock;
  end

  // Transaction-level model: age counts edges since the grant edge.
  bit           m_act  [2];
  int           m_age  [2];
  bit           m_gnt  [2];
  bit           m_last [2];
  logic [2:0]   m_op   [2];
  logic [W-1:0] m_a    [2];
  logic [W-1:0] m_b    [2];
  logic [W-1:0] m_res0 [2];
  logic [W-1:0] m_res1 [2];
  bit           m_done0[2];
  bit           m_done1[2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit winner(input int k);
    if (req0_s[k] && req1_s[k]) return !m_last[k];
    return req1_s[k];
  endfunction

  always @(posedge m_clock or posedge p_reset) begin
    for (int k = 0; k < 2; k++) begin
      if (p_reset) begin
        m_act[k]   <= 1'b0;
        m_age[k]   <= 0;
        m_gnt[k]   <= 1'b0;
        m_last[k]  <= 1'b1;
        m_op[k]    <= '0;
        m_a[k]     <= '0;
        m_b[k]     <= '0;
        m_res0[k]  <= '0;
        m_res1[k]  <= '0;
        m_done0[k] <= 1'b0;
        m_done1[k] <= 1'b0;
      end else if (m_act[k]) begin
        m_age[k] <= m_age[k] + 1;
        if (m_age[k] == lat_of(k)) begin
          if (m_gnt[k]) begin
            m_res1[k]  <= m_a[k] & m_b[k];
            m_done1[k] <= 1'b1;
          end else begin
            m_res0[k]  <= m_a[k] & m_b[k];
            m_done0[k] <= 1'b1;
          end
        end else if (m_age[k] == lat_of(k) + 1) begin
          m_done0[k] <= 1'b0;
          m_done1[k] <= 1'b0;
          m_act[k]   <= 1'b0;
        end
      end else if (req0_s[k] || req1_s[k]) begin
        m_gnt[k]  <= winner(k);
        m_last[k] <= winner(k);
        m_op[k]   <= winner(k) ? op1_s[k] : op0_s[k];
        m_a[k]    <= winner(k) ? a1_s[k] : a0_s[k];
        m_b[k]    <= winner(k) ? b1_s[k] : b0_s[k];
        m_act[k]  <= 1'b1;
        m_age[k]  <= 0;
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  always @(negedge m_clock) begin
    if (!p_reset) begin
      for (int k = 0; k < 2; k++) begin
        check("done0",  k, 32'(done0_s[k]),  32'(m_done0[k]));
        check("done1",  k, 32'(done1_s[k]),  32'(m_done1[k]));
        check("res0",   k, 32'(res0_s[k]),   32'(m_res0[k]));
        check("res1",   k, 32'(res1_s[k]),   32'(m_res1[k]));
        check("alu_op", k, 32'(alu_op_s[k]), 32'(m_op[k]));
        check("alu_a",  k, 32'(alu_a_s[k]),  32'(m_a[k]));
        check("alu_b",  k, 32'(alu_b_s[k]),  32'(m_b[k]));
        check("busy",   k, 32'(busy_s[k]),   32'(m_act[k]));
      end
    end
  end

  task automatic step();
    @(negedge m_clock);
    #1;
  endtask

  task automatic drive(input int k, input int r, input logic rq, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (r == 0) begin
      req0_s[k] = rq; op0_s[k] = op; a0_s[k] = a; b0_s[k] = b;
    end else begin
      req1_s[k] = rq; op1_s[k] = op; a1_s[k] = a; b1_s[k] = b;
    end
  endtask

  task automatic set_req(input int k, input int r, input logic rq);
    if (r == 0) req0_s[k] = rq;
    else        req1_s[k] = rq;
  endtask

  task automatic set_a(input int k, input int r, input logic [W-1:0] a);
    if (r == 0) a0_s[k] = a;
    else        a1_s[k] = a;
  endtask

  function automatic logic get_done(input int k, input int r);
    return (r == 0) ? done0_s[k] : done1_s[k];
  endfunction

  task automatic wait_done(input int k, input int r, input int maxc, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < maxc) begin
      @(negedge m_clock);
      n++;
      seen = get_done(k, r);
    end
    check($sformatf("done%0d within bound", r), k, 32'(seen), 32'd1);
  endtask

  task automatic wait_any(input int k, input int maxc, output int n, output int who);
    n = 0;
    who = -1;
    while (who < 0 && n < maxc) begin
      @(negedge m_clock);
      n++;
      if (done0_s[k]) who = 0;
      else if (done1_s[k]) who = 1;
    end
    check("any done within bound", k, 32'(who >= 0), 32'd1);
  endtask

  task automatic apply_reset();
    p_reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(k, 0, 1'b0, 3'd0, '0, '0);
      drive(k, 1, 1'b0, 3'd0, '0, '0);
    end
    step();
    p_reset = 1'b0;
  endtask

  task automatic agent(input int k, input int r, input int ntx);
    int idle;
    bit seen;
    bit keep;
    keep = 1'b0;
    for (int t = 0; t < ntx; t++) begin
      idle = keep ? 0 : int'($urandom_range(0, 3));
      repeat (idle) step();
      drive(k, r, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge m_clock);
        if (get_done(k, r)) seen = 1'b1;
        else if ($urandom_range(0, 7) == 0) begin
          #1;
          set_a(k, r, 8'($urandom));
        end
      end
      check("agent done within bound", k, 32'(seen), 32'd1);
      #1;
      keep = 1'($urandom_range(0, 1));
      if (!keep) set_req(k, r, 1'b0);
    end
    set_req(k, r, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int who;
    logic [W-1:0] ea [2];
    logic [W-1:0] eb [2];

    p_reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(k, 0, 1'b0, 3'd0, '0, '0);
      drive(k, 1, 1'b0, 3'd0, '0, '0);
    end
    #7;
    for (int k = 0; k < 2; k++) begin
      check("reset done0", k, 32'(done0_s[k]), 32'd0);
      check("reset done1", k, 32'(done1_s[k]), 32'd0);
      check("reset res0",  k, 32'(res0_s[k]),  32'd0);
      check("reset res1",  k, 32'(res1_s[k]),  32'd0);
      check("reset alu_a", k, 32'(alu_a_s[k]), 32'd0);
      check("reset busy",  k, 32'(busy_s[k]),  32'd0);
    end
    step();
    p_reset = 1'b0;

    // Single request on the LATENCY=1 instance.
    drive(0, 0, 1'b1, 3'd5, 8'hF0, 8'h3C);
    @(negedge m_clock);
    check("t1 alu_a", 0, 32'(alu_a_s[0]), 32'hF0);
    check("t1 alu_b", 0, 32'(alu_b_s[0]), 32'h3C);
    check("t1 alu_op", 0, 32'(alu_op_s[0]), 32'd5);
    check("t1 busy", 0, 32'(busy_s[0]), 32'd1);
    wait_done(0, 0, 10, n);
    check("t1 grant-to-done", 0, 32'(n), 32'd2);
    check("t1 res0", 0, 32'(res0_s[0]), 32'h30);
    check("t1 done1", 0, 32'(done1_s[0]), 32'd0);
    #1;
    set_req(0, 0, 1'b0);
    @(negedge m_clock);
    check("t1 done0 cleared", 0, 32'(done0_s[0]), 32'd0);
    check("t1 busy idle", 0, 32'(busy_s[0]), 32'd0);
    check("t1 res0 held", 0, 32'(res0_s[0]), 32'h30);
    #1;

    // Simultaneous requests right after reset: req0 first.
    apply_reset();
    drive(0, 0, 1'b1, 3'd1, 8'hFF, 8'h0F);
    drive(0, 1, 1'b1, 3'd2, 8'hAA, 8'hFF);
    wait_any(0, 10, n, who);
    check("t2 first winner", 0, 32'(who), 32'd0);
    check("t2 first latency", 0, 32'(n), 32'd3);
    check("t2 res0", 0, 32'(res0_s[0]), 32'h0F);
    #1;
    set_req(0, 0, 1'b0);
    wait_any(0, 10, n, who);
    check("t2 second winner", 0, 32'(who), 32'd1);
    check("t2 done spacing", 0, 32'(n), 32'd4);
    check("t2 res1", 0, 32'(res1_s[0]), 32'hAA);
    check("t2 res0 untouched", 0, 32'(res0_s[0]), 32'h0F);
    #1;
    set_req(0, 1, 1'b0);
    step();

    // Sustained contention: strict alternation, 4 cycles apart.
    for (int r = 0; r < 2; r++) begin
      ea[r] = 8'($urandom);
      eb[r] = 8'($urandom);
      drive(0, r, 1'b1, 3'(r + 3), ea[r], eb[r]);
    end
    for (int i = 0; i < 4; i++) begin
      wait_any(0, 20, n, who);
      check("t3 grant order", 0, 32'(who), 32'(i % 2));
      if (i > 0) check("t3 done spacing", 0, 32'(n), 32'd4);
      if (who == 1) check("t3 res1", 0, 32'(res1_s[0]), 32'(ea[1] & eb[1]));
      else          check("t3 res0", 0, 32'(res0_s[0]), 32'(ea[0] & eb[0]));
      #1;
      if (who >= 0) begin
        ea[who] = 8'($urandom);
        eb[who] = 8'($urandom);
        drive(0, who, 1'b1, 3'($urandom), ea[who], eb[who]);
      end
    end
    set_req(0, 0, 1'b0);
    set_req(0, 1, 1'b0);
    step();

    // Operands changing after the grant edge must not reach the unit.
    drive(0, 0, 1'b1, 3'd2, 8'h5A, 8'hFF);
    @(negedge m_clock);
    #1;
    a0_s[0] = 8'h00;
    wait_done(0, 0, 10, n);
    check("t4 latency", 0, 32'(n), 32'd2);
    check("t4 res0", 0, 32'(res0_s[0]), 32'h5A);
    check("t4 alu_a latched", 0, 32'(alu_a_s[0]), 32'h5A);
    #1;
    set_req(0, 0, 1'b0);
    step();

    // Asynchronous reset in the middle of WAIT.
    drive(0, 1, 1'b1, 3'd7, 8'hC3, 8'h0F);
    @(negedge m_clock);
    check("t5 in flight", 0, 32'(busy_s[0]), 32'd1);
    #2;
    p_reset = 1'b1;
    #1;
    check("t5 busy cleared", 0, 32'(busy_s[0]), 32'd0);
    check("t5 done1 none", 0, 32'(done1_s[0]), 32'd0);
    check("t5 alu_a cleared", 0, 32'(alu_a_s[0]), 32'd0);
    check("t5 alu_op cleared", 0, 32'(alu_op_s[0]), 32'd0);
    check("t5 res1 cleared", 0, 32'(res1_s[0]), 32'd0);
    check("t5 res0 cleared", 0, 32'(res0_s[0]), 32'd0);
    #1;
    p_reset = 1'b0;
    wait_done(0, 1, 10, n);
    check("t5 latency after reset", 0, 32'(n), 32'd3);
    check("t5 res1", 0, 32'(res1_s[0]), 32'h03);
    check("t5 done0 quiet", 0, 32'(done0_s[0]), 32'd0);
    #1;
    set_req(0, 1, 1'b0);
    step();

    // LATENCY=3 instance.
    drive(1, 0, 1'b1, 3'd1, 8'h96, 8'h3C);
    wait_done(1, 0, 12, n);
    check("t6 latency", 1, 32'(n), 32'd5);
    check("t6 res0", 1, 32'(res0_s[1]), 32'h14);
    check("t6 alu_a", 1, 32'(alu_a_s[1]), 32'h96);
    #1;
    set_req(1, 0, 1'b0);
    step();

    // Randomized traffic on both instances.
    fork
      agent(0, 0, 30);
      agent(0, 1, 30);
      agent(1, 0, 30);
      agent(1, 1, 30);
    join
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one registered 8-bit ALU datapath unit between two requesters (e.g. the execute sequencer and the address/increment path).
- Arbitrates round-robin, drives the unit's operand/op inputs from registers, and waits the unit's pipeline latency.
- Captures the unit's result and returns it to the granted requester with a one-cycle done pulse.
- Sits between the 8080 control sequencer and the shared ALU register stage.

Parameters:
- W, 8, operand/result width.
- LATENCY, 1, clock edges from operands held stable at the unit input to the result being valid on alu_f (1 for the registered AND/ALU stage).

Ports:
- p_reset  input  1  asynchronous active-high reset
- m_clock  input  1  clock, all state updates on rising edge
- req0  input  1  requester 0 request; held with op0/a0/b0 until done0
- op0  input  3  requester 0 ALU op code
- a0  input  W  requester 0 operand A
- b0  input  W  requester 0 operand B
- done0  output  1  one-cycle pulse: res0 valid
- res0  output  W  requester 0 result, held until next done0
- req1, op1, a1, b1, done1, res1: same as above, for requester 1
- alu_op  output  3  registered op to shared unit
- alu_a  output  W  registered operand A to shared unit
- alu_b  output  W  registered operand B to shared unit
- alu_f  input  W  result from shared unit
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: p_reset, asynchronous, active-high; clock m_clock. While p_reset is high:
  - state=IDLE; alu_op, alu_a, alu_b, res0, res1 = 0; done0 = done1 = 0; busy = 0.
  - last_grant = 1, so req0 wins the first tie.
- Reset mid-operation aborts the in-flight transaction: no done is issued and the result is discarded.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If no req: stay.
  - If exactly one req: grant that requester.
  - If both: grant the requester != last_grant.
  - On the grant edge: latch op/a/b of the winner into alu_op/alu_a/alu_b; record gnt; last_grant <= gnt; cnt <= 0; go to WAIT.
- WAIT:
  - cnt increments each edge.
  - On the edge where cnt == LATENCY: res[gnt] <= alu_f, done[gnt] <= 1, go to RESP.
  - alu_* held constant throughout WAIT.
- RESP:
  - done[gnt] is high for exactly this cycle.
  - The requester must drop req (or present a new operation) during this cycle.
  - Next edge: done <= 0, go to IDLE.
- Latency: req sampled at edge E0 (grant) -> capture at edge E0+LATENCY+1 -> done high in the cycle after that edge.
  - With LATENCY=1: done is seen 2 edges after the grant edge; minimum req-to-req throughput is 4 cycles per transaction.
- Requests arriving during WAIT/RESP are not lost: req is level-held and is re-evaluated in IDLE.
- Fairness:
  - Under continuous requests from both, grants strictly alternate 0,1,0,1.
  - A lone requester may be granted back-to-back.
- alu_* and res* are never modified outside the edges listed above.
- The non-granted requester's done/res never change.
- op is passed through unmodified; the arbiter does not interpret it.

Test Plan:
- Reset then single request: req0=1, a0=8'hF0, b0=8'h3C, with the bench modelling the unit as registered a&b (LATENCY=1) -> alu_a=F0, alu_b=3C after the grant edge; done0 pulses for one cycle with res0=8'h30; done1 stays 0; busy returns to 0.
- Simultaneous requests after reset: req0 and req1 both high (a0=FF,b0=0F; a1=AA,b1=FF) -> req0 served first (res0=0F), then req1 (res1=AA); done pulses never overlap.
- Sustained contention: both reqs held for 4 transactions -> grant order 0,1,0,1; each done spaced 4 cycles apart.
- Operand change during WAIT: bench alters a0 to 00 after the grant edge -> alu_a stays at the latched value; res0 reflects the latched operands.
- Async reset mid-WAIT: assert p_reset between edges -> outputs clear immediately, no done; after release, state is IDLE and a held req1 is granted with the correct result.
- LATENCY=3 instance with a 3-stage unit model: grant-to-done spans 4 edges; res equals the model's a&b.
